// File: rtl/alarm_annunciator_if.sv
// Signal bundle between the monitoring FSM / operator panel and the alarm annunciator.
// The prueba lamp-test input is present only when ANNUNCIATOR_LAMP_TEST_EN is defined.
interface alarm_annunciator_if;
    logic       alarma2;
    logic       alarma3;
    logic       reconocer;
`ifdef ANNUNCIATOR_LAMP_TEST_EN
    logic       prueba;
`endif
    logic       sirena;
    logic       luz_roja;
    logic       luz_amarilla;
    logic [1:0] nivel;
    logic       silenciada;

    modport master (
`ifdef ANNUNCIATOR_LAMP_TEST_EN
        output prueba,
`endif
        output alarma2, alarma3, reconocer,
        input  sirena, luz_roja, luz_amarilla, nivel, silenciada
    );

    modport slave (
`ifdef ANNUNCIATOR_LAMP_TEST_EN
        input  prueba,
`endif
        input  alarma2, alarma3, reconocer,
        output sirena, luz_roja, luz_amarilla, nivel, silenciada
    );
endinterface

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: latches and escalates alarm severity, blinks the lamps, silences the siren on acknowledge.
// Optional lamp test (prueba input) is enabled by defining ANNUNCIATOR_LAMP_TEST_EN.
module alarm_annunciator #(
    parameter int CLK_DIV     = 4,
    parameter int SILENCE_CYC = 10
) (
    input  logic               clk,
    input  logic               rst,
    alarm_annunciator_if.slave bus
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = (SILENCE_CYC > 1) ? $clog2(SILENCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TMR_MAX = TW'(SILENCE_CYC - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ALERT    = 2'd1;
    localparam logic [1:0] S_SILENCED = 2'd2;

    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_WARN = 2'd1;
    localparam logic [1:0] LVL_CRIT = 2'd2;

    logic [1:0]    state, state_n;
    logic [1:0]    nivel_q, nivel_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          phase, phase_n;
    logic [TW-1:0] timer, timer_n;
    logic          reconocer_q;

    logic          sirena_q, roja_q, amarilla_q, silenciada_q;
    logic          sirena_n, roja_n, amarilla_n, silenciada_n;

    logic [1:0]    req;
    logic          ack_edge;
    logic          lamp_test;
    logic          lamp_on;

    always_comb begin
        if (bus.alarma3)      req = LVL_CRIT;
        else if (bus.alarma2) req = LVL_WARN;
        else                  req = LVL_NONE;
    end

    assign ack_edge = bus.reconocer & ~reconocer_q;

`ifdef ANNUNCIATOR_LAMP_TEST_EN
    assign lamp_test = bus.prueba;
`else
    assign lamp_test = 1'b0;
`endif

    always_comb begin
        state_n = state;
        nivel_n = nivel_q;
        cnt_n   = cnt;
        phase_n = phase;
        timer_n = timer;
        case (state)
            S_IDLE: begin
                if (req != LVL_NONE) begin
                    state_n = S_ALERT;
                    nivel_n = req;
                    cnt_n   = '0;
                    phase_n = 1'b1;
                end
            end
            S_ALERT: begin
                // Escalation wins over a simultaneous acknowledge; that edge is lost.
                if (req > nivel_q) begin
                    nivel_n = req;
                    cnt_n   = '0;
                    phase_n = 1'b1;
                end else if (ack_edge) begin
                    state_n = S_SILENCED;
                    timer_n = TMR_MAX;
                end else if (cnt == CNT_MAX) begin
                    cnt_n   = '0;
                    phase_n = ~phase;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_SILENCED: begin
                if (req == LVL_NONE) begin
                    state_n = S_IDLE;
                    nivel_n = LVL_NONE;
                end else if (req > nivel_q) begin
                    state_n = S_ALERT;
                    nivel_n = req;
                    cnt_n   = '0;
                    phase_n = 1'b1;
                end else if (timer == '0) begin
                    state_n = S_ALERT;
                    cnt_n   = '0;
                    phase_n = 1'b1;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                nivel_n = LVL_NONE;
            end
        endcase
    end

    // Outputs are decoded from next-state values so every output is a flop.
    always_comb begin
        lamp_on      = ((state_n == S_ALERT) && phase_n) || (state_n == S_SILENCED);
        sirena_n     = (state_n == S_ALERT);
        silenciada_n = (state_n == S_SILENCED);
        roja_n       = lamp_on && (nivel_n == LVL_CRIT);
        amarilla_n   = lamp_on && (nivel_n == LVL_WARN);
        if ((state_n == S_IDLE) && lamp_test) begin
            sirena_n   = 1'b1;
            roja_n     = 1'b1;
            amarilla_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            nivel_q      <= LVL_NONE;
            cnt          <= '0;
            phase        <= 1'b0;
            timer        <= '0;
            reconocer_q  <= 1'b0;
            sirena_q     <= 1'b0;
            roja_q       <= 1'b0;
            amarilla_q   <= 1'b0;
            silenciada_q <= 1'b0;
        end else begin
            state        <= state_n;
            nivel_q      <= nivel_n;
            cnt          <= cnt_n;
            phase        <= phase_n;
            timer        <= timer_n;
            reconocer_q  <= bus.reconocer;
            sirena_q     <= sirena_n;
            roja_q       <= roja_n;
            amarilla_q   <= amarilla_n;
            silenciada_q <= silenciada_n;
        end
    end

    assign bus.sirena       = sirena_q;
    assign bus.luz_roja     = roja_q;
    assign bus.luz_amarilla = amarilla_q;
    assign bus.nivel        = nivel_q;
    assign bus.silenciada   = silenciada_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// Directed self-checking bench for alarm_annunciator (CLK_DIV=4, SILENCE_CYC=10).
// Observed vector layout: {sirena, luz_roja, luz_amarilla, nivel[1:0], silenciada}.
module tb_alarm_annunciator;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    logic [5:0] exp;
    logic [5:0] obs;

    alarm_annunciator_if bus ();

    alarm_annunciator #(
        .CLK_DIV    (4),
        .SILENCE_CYC(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign obs = {bus.sirena, bus.luz_roja, bus.luz_amarilla, bus.nivel, bus.silenciada};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        bus.alarma2   = 1'b0;
        bus.alarma3   = 1'b0;
        bus.reconocer = 1'b0;
`ifdef ANNUNCIATOR_LAMP_TEST_EN
        bus.prueba    = 1'b0;
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        rst = 1'b1;
        bus.alarma3 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = 6'b000000;
            if (obs !== exp) begin
                $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, exp);
                mismatched++;
            end
            compared++;
        end
        rst = 1'b0;
        tick();
        exp = {1'b1, 1'b1, 1'b0, 2'd2, 1'b0};
        if (obs !== exp) begin
            $display("FAIL reset_release: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_blink_latch;
        logic on;
        do_reset();
        bus.alarma2 = 1'b1;
        tick();
        bus.alarma2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            on  = ((i / 4) % 2) == 0;
            exp = {1'b1, 1'b0, on, 2'd1, 1'b0};
            if (obs !== exp) begin
                $display("FAIL blink[%0d]: got %b want %b", i, obs, exp);
                mismatched++;
            end
            compared++;
            tick();
        end
    endtask

    task automatic test_escalation_ack;
        do_reset();
        bus.alarma2 = 1'b1;
        tick();
        tick();
        bus.alarma3   = 1'b1;
        bus.reconocer = 1'b1;
        tick();
        exp = {1'b1, 1'b1, 1'b0, 2'd2, 1'b0};
        if (obs !== exp) begin
            $display("FAIL esc_collide: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
        bus.reconocer = 1'b0;
        tick();
        if (obs !== exp) begin
            $display("FAIL esc_hold: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
        bus.reconocer = 1'b1;
        tick();
        exp = {1'b0, 1'b1, 1'b0, 2'd2, 1'b1};
        if (obs !== exp) begin
            $display("FAIL esc_ack: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
        // Critical drops to warning: level stays critical and silence continues.
        bus.alarma3 = 1'b0;
        tick();
        if (obs !== exp) begin
            $display("FAIL no_deescalate: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_silence_resound;
        do_reset();
        bus.alarma2 = 1'b1;
        tick();
        tick();
        tick();
        bus.reconocer = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            exp = {1'b0, 1'b0, 1'b1, 2'd1, 1'b1};
            if (obs !== exp) begin
                $display("FAIL silenced[%0d]: got %b want %b", i, obs, exp);
                mismatched++;
            end
            compared++;
            if (i < 9) tick();
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            exp = {1'b1, 1'b0, (i < 4), 2'd1, 1'b0};
            if (obs !== exp) begin
                $display("FAIL resound[%0d]: got %b want %b", i, obs, exp);
                mismatched++;
            end
            compared++;
            tick();
        end
        bus.reconocer = 1'b0;
    endtask

    task automatic test_clear;
        do_reset();
        bus.alarma2 = 1'b1;
        tick();
        bus.reconocer = 1'b1;
        tick();
        bus.reconocer = 1'b0;
        bus.alarma2   = 1'b0;
        tick();
        exp = 6'b000000;
        if (obs !== exp) begin
            $display("FAIL clear: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
        tick();
        if (obs !== exp) begin
            $display("FAIL clear_idle: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
        bus.alarma2 = 1'b1;
        tick();
        exp = {1'b1, 1'b0, 1'b1, 2'd1, 1'b0};
        if (obs !== exp) begin
            $display("FAIL clear_reenter: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_reset_midstate;
        do_reset();
        bus.alarma2 = 1'b1;
        tick();
        bus.reconocer = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        exp = 6'b000000;
        if (obs !== exp) begin
            $display("FAIL rst_silenced: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
        rst = 1'b0;
        tick();
        exp = {1'b1, 1'b0, 1'b1, 2'd1, 1'b0};
        if (obs !== exp) begin
            $display("FAIL rst_reenter: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
        // reconocer held across reset: its edge was consumed in IDLE, so no silence now.
        tick();
        if (obs !== exp) begin
            $display("FAIL rst_held_ack: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
        bus.reconocer = 1'b0;
    endtask

`ifdef ANNUNCIATOR_LAMP_TEST_EN
    task automatic test_lamp;
        do_reset();
        bus.prueba = 1'b1;
        tick();
        exp = {1'b1, 1'b1, 1'b1, 2'd0, 1'b0};
        if (obs !== exp) begin
            $display("FAIL lamp_test: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
        bus.alarma2 = 1'b1;
        tick();
        exp = {1'b1, 1'b0, 1'b1, 2'd1, 1'b0};
        if (obs !== exp) begin
            $display("FAIL lamp_alert: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
        for (int i = 0; i < 4; i++) tick();
        exp = {1'b1, 1'b0, 1'b0, 2'd1, 1'b0};
        if (obs !== exp) begin
            $display("FAIL lamp_blink: got %b want %b", obs, exp);
            mismatched++;
        end
        compared++;
        bus.prueba = 1'b0;
    endtask
`endif

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        bus.alarma2   = 1'b0;
        bus.alarma3   = 1'b0;
        bus.reconocer = 1'b0;
`ifdef ANNUNCIATOR_LAMP_TEST_EN
        bus.prueba    = 1'b0;
`endif
        test_reset();
        test_blink_latch();
        test_escalation_ack();
        test_silence_resound();
        test_clear();
        test_reset_midstate();
`ifdef ANNUNCIATOR_LAMP_TEST_EN
        test_lamp();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
